stream_demux4: RTL and testbench
================================

# stream_demux4

Four-way val/rdy stream demultiplexer with a one-entry pipeline register and per-lane delivery counters. Each input message carries a 2-bit lane select; the block buffers the message and presents it on the selected output lane only, holding it until that lane accepts. It sits between the game controller and the four mole/LED lane handlers, fanning one command stream out to independent consumers.

## Interface
- nbits, 8, message payload width
- cbits, 8, width of each per-lane delivery counter
- clk  in  1  system clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_msg  in  nbits  input payload
- in_sel  in  2  destination lane, 0–3; all four values legal
- in_val  in  1  input message valid
- in_rdy  out  1  block can accept a message this cycle
- out_msg  out  nbits  buffered payload, shared by all lanes; meaningful only where out_val is set
- out_val  out  4  one-hot lane valid; bit i set only when buffered message targets lane i
- out_rdy  in  4  per-lane ready from consumers
- clr  in  1  synchronous clear of all delivery counters
- cnt0..cnt3  out  cbits each  messages delivered to lane 0..3, saturating

## Operation
- State: full_q (1), msg_q (nbits), sel_q (2), cnt_q[0..3] (cbits).
- out_msg = msg_q; out_val[i] = full_q && (sel_q == i); other out_val bits 0.
- deq = full_q && out_rdy[sel_q]; out_rdy bits of non-selected lanes ignored.
- in_rdy = !full_q || deq (combinational path from out_rdy; a full register drains and refills in the same cycle).
- enq = in_val && in_rdy; on enq, msg_q <= in_msg, sel_q <= in_sel.
- full_q next = enq || (full_q && !deq).
- Held message: msg_q, sel_q stable while full_q && !deq; in_msg/in_sel changes ignored until in_rdy.
- Counters: on deq, cnt_q[sel_q] increments by 1, saturating at 2^cbits−1 (no wrap). clr forces all counters to 0 and wins over a same-cycle increment.
- Reset (assertion, any cycle): full_q=0, msg_q=0, sel_q=0, all counters 0; an in-flight message is discarded, not delivered. Outputs while reset_n low: out_val=0, in_rdy=1, out_msg=0, cnt*=0.

## Timing
- Latency: message accepted at edge k appears on out_val/out_msg in the cycle after edge k (1 cycle).
- Throughput: 1 message/cycle sustained when the selected lane is continuously ready, including lane changes every cycle.
- Backpressure: selected lane not ready → full_q held, in_rdy=0 that cycle.
- Counter value reflects deliveries up to and including the previous edge.
- No combinational path from in_val/in_msg/in_sel to any output; only out_rdy → in_rdy is combinational.

## Structure
- Shared package: lane count constant (4), select width constant (2), default nbits/cbits.
- Sub-module: stream_demux_counter (cbits-wide saturating counter with inc and synchronous clr, clr priority, async active-low reset), instantiated four times.
- Output lane decode is a straight one-hot compare of sel_q; no separate mux instance needed.

## Test plan
- Reset then idle: reset_n low 3 cycles → out_val=4'b0000, in_rdy=1, cnt0..cnt3=0; release, no in_val → state unchanged.
- Single delivery: in_msg=8'hA5, in_sel=2, in_val=1 for one cycle, out_rdy=4'b1111 → next cycle out_val=4'b0100, out_msg=8'hA5; following cycle out_val=0, cnt2=1, others 0.
- Backpressure: send 8'h3C to lane 1 with out_rdy[1]=0 for 5 cycles while in_val stays high with 8'h77/lane 0 → out_val=4'b0010, out_msg=8'h3C held, in_rdy=0 throughout; out_rdy[0]=1 ignored; on out_rdy[1]=1, same cycle in_rdy=1, next cycle out_val=4'b0001, out_msg=8'h77.
- Full throughput: stream 8 messages back-to-back, sel cycling 0,1,2,3,0,1,2,3, all out_rdy=1 → one delivery per cycle in order, in_rdy never drops, final cnt0..cnt3=2 each.
- Saturation and clear: cbits=2, deliver 5 messages to lane 3 → cnt3=3 (not 0); assert clr in the same cycle as a lane-3 delivery → cnt3=0 next cycle.
- Reset mid-operation: message 8'hFF to lane 0 held by out_rdy[0]=0, cnt0=1 beforehand; pulse reset_n low asynchronously → out_val=0 and cnt0=0 immediately, message never appears after release.

Source files
------------

// File: rtl/stream_demux4_pkg.sv
// Shared constants and types for the four-way stream demultiplexer.
package stream_demux4_pkg;

  localparam int unsigned LANES     = 4;
  localparam int unsigned SEL_W     = 2;
  localparam int unsigned NBITS_DEF = 8;
  localparam int unsigned CBITS_DEF = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } buf_state_e;

  // One-hot lane decode of a lane select.
  function automatic logic [LANES-1:0] lane_onehot(input logic [SEL_W-1:0] sel);
    return LANES'(1) << sel;
  endfunction

endpackage

// File: rtl/stream_demux_counter.sv
// Saturating delivery counter; synchronous clear takes priority over increment.
module stream_demux_counter
  import stream_demux4_pkg::*;
#(
  parameter int unsigned cbits = CBITS_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clr,
  output logic [cbits-1:0] cnt
);

  localparam logic [cbits-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + cbits'(1);
    end
  end

endmodule

// File: rtl/stream_demux4.sv
// One-entry val/rdy buffer fanning a single stream out to four lanes,
// with a saturating delivery counter per lane.
module stream_demux4
  import stream_demux4_pkg::*;
#(
  parameter int unsigned nbits = NBITS_DEF,
  parameter int unsigned cbits = CBITS_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [nbits-1:0] in_msg,
  input  logic [1:0]       in_sel,
  input  logic             in_val,
  output logic             in_rdy,
  output logic [nbits-1:0] out_msg,
  output logic [3:0]       out_val,
  input  logic [3:0]       out_rdy,
  input  logic             clr,
  output logic [cbits-1:0] cnt0,
  output logic [cbits-1:0] cnt1,
  output logic [cbits-1:0] cnt2,
  output logic [cbits-1:0] cnt3
);

  buf_state_e       state_q;
  buf_state_e       state_d;
  logic [nbits-1:0] msg_q;
  logic [SEL_W-1:0] sel_q;
  logic             full_q;
  logic             enq;
  logic             deq;
  logic [cbits-1:0] cnt_q [LANES];

  assign full_q = (state_q == ST_FULL);

  // Only the selected lane's ready matters; a draining buffer accepts in the same cycle.
  assign deq    = full_q && out_rdy[sel_q];
  assign in_rdy = !full_q || deq;
  assign enq    = in_val && in_rdy;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (enq) state_d = ST_FULL;
      ST_FULL:  if (deq && !enq) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  // Payload and destination load only on accept, so a held message stays stable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      msg_q <= '0;
      sel_q <= '0;
    end else if (enq) begin
      msg_q <= in_msg;
      sel_q <= in_sel;
    end
  end

  assign out_msg = msg_q;
  assign out_val = full_q ? lane_onehot(sel_q) : '0;

  for (genvar g = 0; g < LANES; g++) begin : g_cnt
    stream_demux_counter #(
      .cbits (cbits)
    ) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (deq && (sel_q == SEL_W'(g))),
      .clr     (clr),
      .cnt     (cnt_q[g])
    );
  end

  assign cnt0 = cnt_q[0];
  assign cnt1 = cnt_q[1];
  assign cnt2 = cnt_q[2];
  assign cnt3 = cnt_q[3];

endmodule

// File: tb/tb_stream_demux4.sv
// Directed bench for stream_demux4 with a queue-based reference model checked every cycle.
module tb_stream_demux4;

  localparam int unsigned NB = 8;
  localparam int unsigned CB = 2;
  localparam int unsigned CMAX = (1 << CB) - 1;

  logic          clk;
  logic          reset_n;
  logic [NB-1:0] in_msg;
  logic [1:0]    in_sel;
  logic          in_val;
  logic          in_rdy;
  logic [NB-1:0] out_msg;
  logic [3:0]    out_val;
  logic [3:0]    out_rdy;
  logic          clr;
  logic [CB-1:0] cnt0, cnt1, cnt2, cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  stream_demux4 #(.nbits(NB), .cbits(CB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_msg  (in_msg),
    .in_sel  (in_sel),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .out_msg (out_msg),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .clr     (clr),
    .cnt0    (cnt0),
    .cnt1    (cnt1),
    .cnt2    (cnt2),
    .cnt3    (cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of at most one pending message plus delivery tallies.
  typedef struct {
    logic [NB-1:0] msg;
    logic [1:0]    sel;
  } item_t;

  item_t         mq[$];
  logic [NB-1:0] m_last;
  int            m_cnt[4];

  initial begin
    m_last = '0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  end

  always @(negedge clk) begin
    logic [3:0] e_val;
    logic       e_rdy;
    item_t      it;
    if (!reset_n) begin
      mq.delete();
      m_last = '0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end
    e_val = (mq.size() != 0) ? 4'(1 << mq[0].sel) : 4'b0000;
    e_rdy = (mq.size() == 0) || out_rdy[mq[0].sel];
    check("model out_val", 32'(out_val), 32'(e_val));
    check("model in_rdy",  32'(in_rdy),  32'(e_rdy));
    check("model out_msg", 32'(out_msg), 32'(m_last));
    check("model cnt0", 32'(cnt0), 32'(m_cnt[0]));
    check("model cnt1", 32'(cnt1), 32'(m_cnt[1]));
    check("model cnt2", 32'(cnt2), 32'(m_cnt[2]));
    check("model cnt3", 32'(cnt3), 32'(m_cnt[3]));
    // Advance the model across the coming rising edge.
    if (reset_n) begin
      if (mq.size() != 0 && out_rdy[mq[0].sel]) begin
        it = mq.pop_front();
        if (m_cnt[it.sel] < int'(CMAX)) m_cnt[it.sel]++;
      end
      if (clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      if (in_val && e_rdy) begin
        it.msg = in_msg;
        it.sel = in_sel;
        mq.push_back(it);
        m_last = in_msg;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NB-1:0] m, input logic [1:0] s, input logic v);
    in_msg = m;
    in_sel = s;
    in_val = v;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(8'h00, 2'd0, 1'b0);
    out_rdy = 4'b1111;
    clr     = 1'b0;

    // Reset held for three cycles, then idle
    repeat (3) step();
    #1;
    check("reset out_val", 32'(out_val), 32'h0);
    check("reset in_rdy",  32'(in_rdy),  32'h1);
    check("reset cnt2",    32'(cnt2),    32'h0);
    reset_n = 1'b1;
    repeat (2) step();
    check("idle out_val", 32'(out_val), 32'h0);

    // Single delivery to lane 2
    drive(8'hA5, 2'd2, 1'b1);
    step();
    drive(8'h00, 2'd0, 1'b0);
    #1;
    check("single out_val", 32'(out_val), 32'h4);
    check("single out_msg", 32'(out_msg), 32'hA5);
    step();
    check("single drained", 32'(out_val), 32'h0);
    check("single cnt2",    32'(cnt2),    32'h1);
    check("single cnt0",    32'(cnt0),    32'h0);

    // Backpressure on lane 1 while a lane-0 message waits at the input
    out_rdy = 4'b1101;
    drive(8'h3C, 2'd1, 1'b1);
    step();
    drive(8'h77, 2'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp out_val", 32'(out_val), 32'h2);
      check("bp out_msg", 32'(out_msg), 32'h3C);
      check("bp in_rdy",  32'(in_rdy),  32'h0);
      step();
    end
    out_rdy = 4'b1111;
    #1;
    check("bp release in_rdy", 32'(in_rdy), 32'h1);
    step();
    drive(8'h00, 2'd0, 1'b0);
    #1;
    check("bp next out_val", 32'(out_val), 32'h1);
    check("bp next out_msg", 32'(out_msg), 32'h77);
    step();

    clr = 1'b1;
    step();
    clr = 1'b0;

    // Back-to-back stream cycling through all lanes
    for (int i = 0; i < 8; i++) begin
      drive(NB'(8'h10 + i), 2'(i % 4), 1'b1);
      #1;
      if (i > 0) begin
        check("tp out_val", 32'(out_val), 32'(1 << ((i - 1) % 4)));
        check("tp out_msg", 32'(out_msg), 32'(8'h10 + i - 1));
        check("tp in_rdy",  32'(in_rdy),  32'h1);
      end
      step();
    end
    drive(8'h00, 2'd0, 1'b0);
    #1;
    check("tp last out_val", 32'(out_val), 32'h8);
    check("tp last out_msg", 32'(out_msg), 32'h17);
    step();
    check("tp cnt0", 32'(cnt0), 32'h2);
    check("tp cnt1", 32'(cnt1), 32'h2);
    check("tp cnt2", 32'(cnt2), 32'h2);
    check("tp cnt3", 32'(cnt3), 32'h2);

    // Saturation: five deliveries to lane 3 with a 2-bit counter
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(NB'(8'h30 + i), 2'd3, 1'b1);
      step();
    end
    drive(8'h00, 2'd0, 1'b0);
    step();
    check("sat cnt3", 32'(cnt3), 32'h3);

    // Clear wins over a same-cycle lane-3 delivery
    drive(8'h44, 2'd3, 1'b1);
    step();
    drive(8'h00, 2'd0, 1'b0);
    clr = 1'b1;
    #1;
    check("clr race out_val", 32'(out_val), 32'h8);
    step();
    clr = 1'b0;
    check("clr race cnt3",    32'(cnt3),    32'h0);
    check("clr race drained", 32'(out_val), 32'h0);

    // Asynchronous reset while a message is held
    drive(8'h12, 2'd0, 1'b1);
    step();
    drive(8'h00, 2'd0, 1'b0);
    step();
    check("pre-reset cnt0", 32'(cnt0), 32'h1);
    out_rdy = 4'b1110;
    drive(8'hFF, 2'd0, 1'b1);
    step();
    drive(8'h00, 2'd0, 1'b0);
    #1;
    check("held out_val", 32'(out_val), 32'h1);
    check("held out_msg", 32'(out_msg), 32'hFF);
    #1;
    reset_n = 1'b0;
    #1;
    check("async out_val", 32'(out_val), 32'h0);
    check("async cnt0",    32'(cnt0),    32'h0);
    check("async in_rdy",  32'(in_rdy),  32'h1);
    check("async out_msg", 32'(out_msg), 32'h0);
    step();
    reset_n = 1'b1;
    out_rdy = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post-reset out_val", 32'(out_val), 32'h0);
      check("post-reset cnt0",    32'(cnt0),    32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
